// File: rtl/alu_pkg.sv
// alu_pkg: opcode and flag-index definitions shared by the ALU files.
//   alu_op_e   4-bit command codes driven on cmnd
//   FLAG_Z/C/N bit positions inside the 3-bit flags word
package alu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD      = 4'h0,
      ALU_SUBTRACT = 4'h1,
      ALU_MULTIPLY = 4'h2,
      ALU_AND      = 4'h3,
      ALU_OR       = 4'h4,
      ALU_XOR      = 4'h5,
      ALU_NOT      = 4'h6,
      ALU_LSL      = 4'h7,
      ALU_LSR      = 4'h8,
      ALU_ASR      = 4'h9,
      ALU_TWOS     = 4'hA,
      ALU_INC      = 4'hB,
      ALU_DEC      = 4'hC,
      ALU_PASS_A   = 4'hD,
      ALU_CMP      = 4'hE,
      ALU_NOP      = 4'hF
   } alu_op_e;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 0;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational datapath computing the next result/flags for one command.
//   a, b         8-bit operands
//   cmnd         4-bit command (alu_op_e)
//   next_result  16-bit candidate result
//   next_flags   candidate {Z,C,N}
//   hold_result  keep the registered result (NOP, CMP)
//   hold_flags   keep the registered flags (NOP)
module alu_core
   import alu_pkg::*;
(
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic [3:0]  cmnd,
   output logic [15:0] next_result,
   output logic [2:0]  next_flags,
   output logic        hold_result,
   output logic        hold_flags
);
   logic [7:0]  r8;
   logic [15:0] prod;
   logic        c;
   logic        mul;
   always_comb begin
      r8          = 8'h00;
      c           = 1'b0;
      mul         = 1'b0;
      hold_result = 1'b0;
      hold_flags  = 1'b0;
      prod        = 16'(a) * 16'(b);
      case (alu_op_e'(cmnd))
         ALU_ADD:      {c, r8} = {1'b0, a} + {1'b0, b};
         ALU_SUBTRACT: begin r8 = a - b; c = a < b; end
         ALU_MULTIPLY: mul = 1'b1;
         ALU_AND:      r8 = a & b;
         ALU_OR:       r8 = a | b;
         ALU_XOR:      r8 = a ^ b;
         ALU_NOT:      r8 = ~a;
         ALU_LSL:      begin r8 = {a[6:0], 1'b0}; c = a[7]; end
         ALU_LSR:      begin r8 = {1'b0, a[7:1]}; c = a[0]; end
         ALU_ASR:      begin r8 = {a[7], a[7:1]}; c = a[0]; end
         ALU_TWOS:     begin r8 = ~a + 8'd1; c = (a == 8'h00); end
         ALU_INC:      begin r8 = a + 8'd1; c = (a == 8'hFF); end
         ALU_DEC:      begin r8 = a - 8'd1; c = (a == 8'h00); end
         ALU_PASS_A:   r8 = a;
         // CMP updates flags exactly like SUBTRACT but leaves the result alone
         ALU_CMP:      begin r8 = a - b; c = a < b; hold_result = 1'b1; end
         default:      begin hold_result = 1'b1; hold_flags = 1'b1; end
      endcase
      next_result        = mul ? prod : {8'h00, r8};
      next_flags[FLAG_Z] = mul ? (prod == 16'h0000) : (r8 == 8'h00);
      next_flags[FLAG_C] = mul ? (prod[15:8] != 8'h00) : c;
      next_flags[FLAG_N] = mul ? prod[15] : r8[7];
   end
endmodule

// File: rtl/alu.sv
// alu: 8-bit ALU with registered 16-bit result and {Z,C,N} flags, one-cycle latency.
//   clk                rising-edge clock
//   reset              asynchronous active-low reset
//   primary_operand    operand A
//   secondary_operand  operand B
//   cmnd               operation select (alu_op_e)
//   result             registered result
//   flags              registered {Z,C,N}
module alu
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  primary_operand,
   input  logic [7:0]  secondary_operand,
   input  logic [3:0]  cmnd,
   output logic [15:0] result,
   output logic [2:0]  flags
);
   logic [15:0] next_result;
   logic [2:0]  next_flags;
   logic        hold_result;
   logic        hold_flags;
   alu_core u_core (
      .a           (primary_operand),
      .b           (secondary_operand),
      .cmnd        (cmnd),
      .next_result (next_result),
      .next_flags  (next_flags),
      .hold_result (hold_result),
      .hold_flags  (hold_flags)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result <= 16'h0000;
         flags  <= 3'b000;
      end else begin
         if (!hold_result) result <= next_result;
         if (!hold_flags)  flags  <= next_flags;
      end
   end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random stimulus for alu, checked against an arithmetic reference model.
module tb_alu;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  primary_operand = 8'h00;
   logic [7:0]  secondary_operand = 8'h00;
   logic [3:0]  cmnd = 4'hF;
   logic [15:0] result;
   logic [2:0]  flags;
   logic [15:0] exp_r = 16'h0000;
   logic [2:0]  exp_f = 3'b000;
   int          checks = 0;
   int          errors = 0;

   alu dut (
      .clk               (clk),
      .reset             (reset),
      .primary_operand   (primary_operand),
      .secondary_operand (secondary_operand),
      .cmnd              (cmnd),
      .result            (result),
      .flags             (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_result"}, result, exp_r);
      check({tag, "_flags"}, {13'd0, flags}, {13'd0, exp_f});
   endtask

   // Reference model: integer arithmetic straight from the opcode rules.
   task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int av, bv, r, m;
      logic z, c, n;
      av = int'(a);
      bv = int'(b);
      r = 0;
      m = 0;
      c = 1'b0;
      case (op)
         4'h0: begin r = av + bv; c = (r > 255); end
         4'h1, 4'hE: begin r = av - bv; c = (av < bv); end
         4'h2: m = av * bv;
         4'h3: r = int'(a & b);
         4'h4: r = int'(a | b);
         4'h5: r = int'(a ^ b);
         4'h6: r = 255 - av;
         4'h7: begin r = av * 2; c = (av >= 128); end
         4'h8: begin r = av / 2; c = (av % 2 == 1); end
         4'h9: begin r = av / 2 + (av >= 128 ? 128 : 0); c = (av % 2 == 1); end
         4'hA: begin r = 256 - av; c = (av == 0); end
         4'hB: begin r = av + 1; c = (av == 255); end
         4'hC: begin r = av - 1; c = (av == 0); end
         4'hD: r = av;
         default: return;
      endcase
      if (op == 4'h2) begin
         z = (m == 0);
         n = (m >= 32768);
         c = (m > 255);
         exp_r = 16'(m);
      end else begin
         r = (r + 256) % 256;
         z = (r == 0);
         n = (r >= 128);
         if (op != 4'hE) exp_r = 16'(r);
      end
      exp_f = {z, c, n};
   endtask

   task automatic step(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      cmnd = op;
      primary_operand = a;
      secondary_operand = b;
      @(posedge clk);
      #1;
      model(op, a, b);
      check_state(tag);
   endtask

   function automatic logic [7:0] pick();
      logic [7:0] edges [4];
      edges = '{8'h00, 8'h01, 8'h80, 8'hFF};
      return ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 8'($urandom);
   endfunction

   initial begin
      primary_operand = 8'h5A;
      secondary_operand = 8'hC3;
      cmnd = 4'h0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_state("reset_hold");
      end
      @(negedge clk);
      reset = 1'b1;

      step("add_10_5",   4'h0, 8'd10, 8'd5);
      check("add_10_5_const", result, 16'h000F);
      step("sub_10_3",   4'h1, 8'd10, 8'd3);
      step("sub_3_10",   4'h1, 8'd3,  8'd10);
      check("sub_3_10_flags_const", {13'd0, flags}, 16'h0003);
      step("add_ff_01",  4'h0, 8'hFF, 8'h01);
      check("add_ff_01_flags_const", {13'd0, flags}, 16'h0006);
      step("mul_4_5",    4'h2, 8'd4,  8'd5);
      step("mul_ff_ff",  4'h2, 8'hFF, 8'hFF);
      check("mul_ff_ff_const", result, 16'hFE01);
      step("and",        4'h3, 8'hF0, 8'h0F);
      step("or",         4'h4, 8'hF0, 8'h0F);
      step("xor",        4'h5, 8'hAA, 8'hAA);
      step("not",        4'h6, 8'h3C, 8'h00);
      step("lsl_01",     4'h7, 8'h01, 8'h77);
      step("lsl_80",     4'h7, 8'h80, 8'h00);
      step("lsr_01",     4'h8, 8'h01, 8'hFF);
      step("asr_80",     4'h9, 8'h80, 8'h00);
      check("asr_80_const", result, 16'h00C0);
      step("twos_01",    4'hA, 8'h01, 8'h00);
      step("twos_00",    4'hA, 8'h00, 8'h00);
      step("twos_80",    4'hA, 8'h80, 8'h00);
      step("inc_ff",     4'hB, 8'hFF, 8'h00);
      step("dec_00",     4'hC, 8'h00, 8'h00);
      step("pass_a",     4'hD, 8'h9E, 8'h11);
      step("cmp_5_5",    4'hE, 8'h05, 8'h05);
      check("cmp_keeps_result", result, 16'h009E);
      step("cmp_3_9",    4'hE, 8'h03, 8'h09);
      step("nop",        4'hF, 8'h12, 8'h34);

      step("pre_async",  4'h2, 8'hC8, 8'h07);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      exp_r = 16'h0000;
      exp_f = 3'b000;
      check_state("async_reset");
      @(negedge clk);
      reset = 1'b1;
      step("after_reset", 4'h1, 8'h00, 8'h01);

      for (int i = 0; i < 400; i++) begin
         step("random", 4'($urandom_range(0, 15)), pick(), pick());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: observed no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
